vram_writer_m: RTL and testbench
================================

Name: vram_writer_m

Overview:
- CPU-side initiator that drives the VRAM write interface of gpu_top_m: `address`, `data`, `cs`.
- Accepts byte-write/fill requests from the CPU bus, buffers them in a small FIFO, and replays them as address/data/strobe cycles.
- Writes only occur while the GPU's write window (vblank) is open, so VRAM is never written during active scan-out.

Parameters:
- ADDR_WIDTH, `VRAM_ADDR_WIDTH (parameters.v), VRAM address width.
- DEPTH, 4, request FIFO entries; power of two, at least 2.
- CW, 3, width of fifo_count; equals log2(DEPTH)+1.

Ports:
- clk  in  1  system clock (12.5875 MHz).
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  FIFO can accept a request; equals !full.
- req_addr  in  ADDR_WIDTH  first VRAM address.
- req_data  in  8  byte to write.
- req_len  in  8  byte count minus one (0 means 1 byte, 255 means 256 bytes).
- window  in  1  high when VRAM writes are permitted (vblank from GPU timing).
- address  out  ADDR_WIDTH  VRAM address.
- data  out  8  VRAM write data.
- cs  out  1  active-high write strobe, one cycle per byte.
- busy  out  1  FIFO non-empty or engine not IDLE.
- fifo_count  out  CW  occupied FIFO entries.

Behaviour:
- Reset (rst=0, async): address=0, data=0, cs=0, busy=0, fifo_count=0, FIFO emptied, state=IDLE. req_ready reads 1.
- Reset mid-operation: cs drops immediately; the in-flight write and all queued entries are discarded.
- Push: a request is accepted on an edge where req_valid && req_ready. The FIFO stores {addr, data, len}.
- Push and pop on the same edge are legal. When full, ready is 0 and there is no push-through.
- Engine states:
  - IDLE: if FIFO non-empty && window, pop the head into cur_addr/cur_data/remaining and go to SETUP. Otherwise stay.
  - SETUP: address=cur_addr, data=cur_data, cs=0. Go to STROBE.
  - STROBE: cs=1; address and data unchanged. Go to HOLD.
  - HOLD: cs=0; address and data unchanged.
    - If remaining==0, go to IDLE.
    - Else decrement remaining, increment cur_addr, then go to SETUP if window, else PAUSE.
  - PAUSE: cs=0; outputs hold their last values. When window rises, go to SETUP with the current cursor.
- Window is sampled only in IDLE, HOLD and PAUSE. A write that has reached SETUP always completes STROBE and HOLD, even if window falls.
- Timing:
  - Address/data are stable one cycle before, during, and one cycle after cs.
  - Throughput is 3 cycles per byte.
  - Latency: for acceptance edge E with engine IDLE, FIFO empty and window=1, the FIFO registers the entry at E. The engine pops at E+1 (SETUP outputs valid), cs=1 after E+2, and cs=0 after E+3.
- Address arithmetic is modulo 2^ADDR_WIDTH: max wraps to 0.
- Data is constant across a fill.
- Requests are served strictly in FIFO order. A fill is never interleaved with another request.
- Outside writes, address and data keep their last driven values; only cs is meaningful to VRAM.

Decomposition:
- VRAM_ADDR_WIDTH and the state encodings (IDLE, SETUP, STROBE, HOLD, PAUSE) live in parameters.v.
- The FIFO is a natural sub-module: vram_req_fifo_m, a synchronous FIFO with parameters DEPTH and WIDTH=ADDR_WIDTH+16, providing full, empty and count.
- The engine FSM plus cursor registers stay in vram_writer_m.

Test Plan:
- Reset: assert rst=0 mid-STROBE -> cs=0 immediately. After release: fifo_count=0, busy=0, req_ready=1, address=0.
- Single write: window=1, addr 0x123, data 0xA5, len 0 -> exactly one cs pulse at address 0x123/data 0xA5, 2 cycles after acceptance. Address/data are stable in the cycle before and after the pulse; busy falls after HOLD.
- Fill: addr 0x010, data 0x00, len 3 -> four cs pulses at 0x010, 0x011, 0x012, 0x013, exactly 3 cycles apart.
- Window gap: len 7; drop window during the 2nd STROBE and raise it 10 cycles later -> 2nd write completes, engine goes to PAUSE after HOLD, then resumes at addr+2. Total 8 pulses, no duplicates or skips.
- Backpressure: window=0, offer 5 requests (DEPTH=4) -> 4 accepted, req_ready=0, fifo_count=4. Raise window -> all 4 drained in push order; the 5th is accepted once ready=1.
- Wrap: addr = 2^ADDR_WIDTH-1, len 1 -> pulses at max address, then at 0.

Source files
------------

// File: rtl/vram_writer_m_pkg.sv
// Shared constants for the VRAM write initiator: default address width and
// engine state encodings.
package vram_writer_m_pkg;

  localparam int VRAM_ADDR_WIDTH = 12;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;

endpackage

// File: rtl/vram_writer_m_if.sv
// CPU-side request channel: valid/ready handshake carrying a byte-fill request.
interface vram_writer_m_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [7:0]            req_data;
  logic [7:0]            req_len;

  modport master (output req_valid, req_addr, req_data, req_len, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, req_len, output req_ready);
endinterface

// File: rtl/vram_writer_m_fifo.sv
// Synchronous request FIFO; pointers carry one extra bit so full/empty fall out of
// their difference.
module vram_req_fifo_m #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wp, rp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + CW'(1);
      if (pop)  rp <= rp + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end

  assign count = wp - rp;
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rp[AW-1:0]];
endmodule

// File: rtl/vram_writer_m.sv
// VRAM write initiator: queues CPU byte-fill requests and replays them as
// setup/strobe/hold cycles, only while the GPU write window is open.
module vram_writer_m
  import vram_writer_m_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  vram_writer_m_if.slave        req,
  input  logic                  window,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [7:0]            data,
  output logic                  cs,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count
);
  localparam int W = ADDR_WIDTH + 16;

  logic                  push, pop, full, empty;
  logic [W-1:0]          head;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [7:0]            head_data, head_len;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [7:0]            remaining;

  assign req.req_ready = !full;
  assign push          = req.req_valid && !full;
  assign pop           = (state == S_IDLE) && !empty && window;
  assign {head_addr, head_data, head_len} = head;
  assign busy          = !empty || (state != S_IDLE);

  vram_req_fifo_m #(
    .DEPTH (DEPTH),
    .WIDTH (W),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req.req_addr, req.req_data, req.req_len}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // cur_addr runs ahead of address while paused so the visible bus holds still.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cs        <= 1'b0;
      address   <= '0;
      data      <= '0;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_addr  <= head_addr;
            address   <= head_addr;
            data      <= head_data;
            remaining <= head_len;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          cs    <= 1'b1;
          state <= S_STROBE;
        end
        S_STROBE: begin
          cs    <= 1'b0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (remaining == 8'd0) begin
            state <= S_IDLE;
          end else begin
            remaining <= remaining - 8'd1;
            cur_addr  <= cur_addr + ADDR_WIDTH'(1);
            if (window) begin
              address <= cur_addr + ADDR_WIDTH'(1);
              state   <= S_SETUP;
            end else begin
              state <= S_PAUSE;
            end
          end
        end
        S_PAUSE: begin
          if (window) begin
            address <= cur_addr;
            state   <= S_SETUP;
          end
        end
        default: begin
          cs    <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vram_writer_m.sv
// Directed bench for vram_writer_m: table of single/fill/wrap requests plus
// hand-written window-gap, backpressure and reset sequences.
module tb_vram_writer_m;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          window;
  logic [AW-1:0] address;
  logic [7:0]    data;
  logic          cs;
  logic          busy;
  logic [2:0]    fifo_count;

  vram_writer_m_if #(.ADDR_WIDTH(AW)) rif ();

  vram_writer_m #(.ADDR_WIDTH(AW), .DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (rif),
    .window     (window),
    .address    (address),
    .data       (data),
    .cs         (cs),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int miss = 0;

  logic [AW-1:0] p_addr[$];
  logic [7:0]    p_data[$];
  int            p_cyc[$];
  logic [AW-1:0] h_addr [0:16383];
  logic [7:0]    h_data [0:16383];
  logic          h_cs   [0:16383];

  always @(negedge clk) begin
    h_addr[cyc % 16384] = address;
    h_data[cyc % 16384] = data;
    h_cs[cyc % 16384]   = cs;
    if (cs && rst) begin
      p_addr.push_back(address);
      p_data.push_back(data);
      p_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [7:0]    len;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vecs++;
    if (act !== exp_v) begin
      miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic clear_log();
    p_addr.delete();
    p_data.delete();
    p_cyc.delete();
  endtask

  function automatic bit stable_at(input int c);
    logic [AW-1:0] a;
    logic [7:0]    d;
    a = h_addr[c % 16384];
    d = h_data[c % 16384];
    return (h_cs[(c - 1) % 16384] == 1'b0) && (h_cs[(c + 1) % 16384] == 1'b0) &&
           (h_addr[(c - 1) % 16384] == a) && (h_addr[(c + 1) % 16384] == a) &&
           (h_data[(c - 1) % 16384] == d) && (h_data[(c + 1) % 16384] == d);
  endfunction

  task automatic wait_idle(output int low_cyc);
    low_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        low_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_req(input vec_t v, input string tag);
    int e, low;
    logic [AW-1:0] ea;
    clear_log();
    @(negedge clk);
    rif.req_addr  = v.addr;
    rif.req_data  = v.data;
    rif.req_len   = v.len;
    rif.req_valid = 1'b1;
    @(negedge clk);
    rif.req_valid = 1'b0;
    e = cyc;
    wait_idle(low);
    chk({tag, " busy_fall_cycle"}, low - e, 4 + 3 * int'(v.len));
    chk({tag, " pulse_count"}, p_cyc.size(), int'(v.len) + 1);
    for (int i = 0; i < p_cyc.size(); i++) begin
      ea = v.addr + AW'(i);
      chk({tag, " addr"}, p_addr[i], ea);
      chk({tag, " data"}, p_data[i], v.data);
      chk({tag, " pulse_cycle"}, p_cyc[i] - e, 2 + 3 * i);
      chk({tag, " stable"}, stable_at(p_cyc[i]), 1);
    end
  endtask

  vec_t tbl[4];

  initial begin
    int e, n, low, tmo;
    tbl[0] = '{addr: 12'h123, data: 8'hA5, len: 8'd0};
    tbl[1] = '{addr: 12'h010, data: 8'h00, len: 8'd3};
    tbl[2] = '{addr: 12'hFFF, data: 8'h77, len: 8'd1};
    tbl[3] = '{addr: 12'h7FE, data: 8'h3C, len: 8'd2};

    rst = 1'b0;
    window = 1'b1;
    rif.req_valid = 1'b0;
    rif.req_addr  = '0;
    rif.req_data  = '0;
    rif.req_len   = '0;
    repeat (3) @(negedge clk);
    chk("reset cs", cs, 0);
    chk("reset busy", busy, 0);
    chk("reset fifo_count", fifo_count, 0);
    chk("reset req_ready", rif.req_ready, 1);
    chk("reset address", address, 0);
    chk("reset data", data, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Window gap: drop window during the second strobe, reopen 10 cycles later.
    clear_log();
    @(negedge clk);
    rif.req_addr = 12'h200; rif.req_data = 8'h5A; rif.req_len = 8'd7;
    rif.req_valid = 1'b1;
    @(negedge clk);
    rif.req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(negedge clk);
      if (cs) n++;
    end
    chk("gap second strobe seen", n, 2);
    window = 1'b0;
    repeat (10) @(negedge clk);
    window = 1'b1;
    wait_idle(low);
    chk("gap pulse_count", p_cyc.size(), 8);
    for (int i = 0; i < p_cyc.size(); i++) begin
      chk("gap addr", p_addr[i], 12'h200 + AW'(i));
      chk("gap data", p_data[i], 8'h5A);
    end
    if (p_cyc.size() >= 4) begin
      chk("gap pause spacing", p_cyc[2] - p_cyc[1], 12);
      chk("gap resume spacing", p_cyc[3] - p_cyc[2], 3);
    end

    // Backpressure: four requests fill the FIFO while the window is closed.
    clear_log();
    window = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rif.req_addr = 12'h300 + AW'(i); rif.req_data = 8'h10 + 8'(i); rif.req_len = 8'd0;
      rif.req_valid = 1'b1;
    end
    @(negedge clk);
    rif.req_addr = 12'h304; rif.req_data = 8'h14; rif.req_len = 8'd0;
    chk("bp fifo_count full", fifo_count, 4);
    chk("bp req_ready low", rif.req_ready, 0);
    chk("bp busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("bp no writes while closed", p_cyc.size(), 0);
    window = 1'b1;
    tmo = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rif.req_ready) begin
        tmo = 0;
        break;
      end
    end
    chk("bp ready returned", tmo, 0);
    @(negedge clk);
    rif.req_valid = 1'b0;
    wait_idle(low);
    chk("bp pulse_count", p_cyc.size(), 5);
    for (int i = 0; i < p_cyc.size(); i++) begin
      chk("bp order addr", p_addr[i], 12'h300 + AW'(i));
      chk("bp order data", p_data[i], 8'h10 + 8'(i));
    end

    // Reset mid-strobe discards the in-flight fill and the queued request.
    @(negedge clk);
    rif.req_addr = 12'h400; rif.req_data = 8'hC3; rif.req_len = 8'd7;
    rif.req_valid = 1'b1;
    @(negedge clk);
    rif.req_addr = 12'h500; rif.req_data = 8'h99; rif.req_len = 8'd0;
    @(negedge clk);
    rif.req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 50 && n == 0; i++) begin
      @(negedge clk);
      if (cs) n = 1;
    end
    chk("rst strobe reached", n, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst async cs", cs, 0);
    chk("rst async fifo_count", fifo_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst release fifo_count", fifo_count, 0);
    chk("rst release busy", busy, 0);
    chk("rst release req_ready", rif.req_ready, 1);
    chk("rst release address", address, 0);
    clear_log();
    repeat (20) @(negedge clk);
    chk("rst discarded writes", p_cyc.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
